envelope_gen: RTL and testbench

- Per-channel ADSR amplitude envelope. Sits between one wave generator output (pulse/triangle/noise, 8-bit) and the mix4 mixer input.
- Gate comes from beat logic: high while the channel's tone nibble is non-zero and the note is held.
- Runs on the slow (chip) clock. Outputs the scaled 8-bit sample plus envelope status.

---
 rtl/envelope_gen.sv | 142 ++++++++++++++
 tb/tb_envelope_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/envelope_gen.sv
// Per-channel ADSR amplitude envelope: scales one 8-bit wave sample by an 8-bit level.
// Build option: define ENVELOPE_RETRIG_ZERO_EN for hard retrigger (level forced to 0 on gate rise).
module envelope_gen #(
  parameter logic [31:0] PRESCALE = 32'd12_288
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gate,
  input  logic [7:0] samp_in,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  output logic [7:0] samp_out,
  output logic [7:0] level,
  output logic [2:0] state,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_e;

  env_state_e st_q, st_d;
  logic [31:0] presc_q;
  logic        tick;
  logic        gate_q, armed_q;
  logic        rise, fall;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [7:0]  lvl_q, lvl_d;
  logic [7:0]  rate;
  logic        step;
  logic        stepping;

  // Free-running envelope tick; gate activity never disturbs its phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          presc_q <= '0;
    else if (presc_q == PRESCALE - 32'd1) presc_q <= '0;
    else                                 presc_q <= presc_q + 32'd1;
  end

  assign tick = (presc_q == PRESCALE - 32'd1);

  // armed stays low until gate is seen low, so a gate held through reset is not a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      gate_q  <= gate;
      armed_q <= armed_q | ~gate;
    end
  end

  assign rise = gate & ~gate_q & armed_q;
  assign fall = ~gate & gate_q;

  always_comb begin
    rate = 8'd0;
    case (st_q)
      ATTACK:  rate = attack_rate;
      DECAY:   rate = decay_rate;
      RELEASE: rate = release_rate;
      default: rate = 8'd0;
    endcase
  end

  assign stepping = (st_q == ATTACK) || (st_q == DECAY) || (st_q == RELEASE);
  assign step     = tick && (step_cnt_q >= rate);

  always_comb begin
    st_d  = st_q;
    lvl_d = lvl_q;
    if (rise) begin
      st_d = ATTACK;
`ifdef ENVELOPE_RETRIG_ZERO_EN
      lvl_d = 8'd0;
`endif
    end else if (fall && (st_q == ATTACK || st_q == DECAY || st_q == SUSTAIN)) begin
      st_d = RELEASE;
    end else begin
      case (st_q)
        IDLE: lvl_d = 8'd0;
        ATTACK: begin
          if (lvl_q == 8'hFF) begin
            st_d = DECAY;
          end else if (step) begin
            lvl_d = lvl_q + 8'd1;
            if (lvl_q == 8'hFE) st_d = DECAY;
          end
        end
        DECAY: begin
          if (lvl_q <= sustain_level) st_d = SUSTAIN;
          else if (step)              lvl_d = lvl_q - 8'd1;
        end
        SUSTAIN: lvl_d = sustain_level;
        RELEASE: begin
          if (lvl_q == 8'd0) begin
            st_d = IDLE;
          end else if (step) begin
            lvl_d = lvl_q - 8'd1;
            if (lvl_q == 8'd1) st_d = IDLE;
          end
        end
        default: begin
          st_d  = IDLE;
          lvl_d = 8'd0;
        end
      endcase
    end
  end

  // Step timing restarts on every phase entry, including a retrigger into ATTACK.
  always_comb begin
    step_cnt_d = step_cnt_q;
    if (rise || (st_d != st_q) || !stepping) step_cnt_d = 8'd0;
    else if (tick)                           step_cnt_d = step ? 8'd0 : step_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= IDLE;
      lvl_q      <= 8'd0;
      step_cnt_q <= 8'd0;
      samp_out   <= 8'd0;
    end else begin
      st_q       <= st_d;
      lvl_q      <= lvl_d;
      step_cnt_q <= step_cnt_d;
      samp_out   <= 8'((16'(samp_in) * 16'(lvl_q)) >> 8);
    end
  end

  assign level = lvl_q;
  assign state = st_q;
  assign busy  = (st_q != IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen at PRESCALE=4; expected values hand-derived from tick timing.
module tb_envelope_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gate = 1'b0;
  logic [7:0] samp_in = 8'd255;
  logic [7:0] attack_rate = 8'd0;
  logic [7:0] decay_rate = 8'd0;
  logic [7:0] sustain_level = 8'd128;
  logic [7:0] release_rate = 8'd0;
  logic [7:0] samp_out;
  logic [7:0] level;
  logic [2:0] state;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n;
  int exp_retrig0, exp_retrig1;

  always #5 clk = ~clk;

  envelope_gen #(.PRESCALE(32'd4)) dut (
    .clk(clk), .reset(reset), .gate(gate), .samp_in(samp_in),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .samp_out(samp_out), .level(level), .state(state), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, output int cnt);
    cnt = 0;
    while (state !== s && cnt < lim) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic wait_level(input logic [7:0] v, input int lim, output int cnt);
    cnt = 0;
    while (level !== v && cnt < lim) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
`ifdef ENVELOPE_RETRIG_ZERO_EN
    exp_retrig0 = 0;
    exp_retrig1 = 1;
`else
    exp_retrig0 = 60;
    exp_retrig1 = 61;
`endif
    #2 reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_samp_out", 32'(samp_out), 0);
    chk("rst_busy", 32'(busy), 0);
    cyc(3);
    reset = 1'b1;
    cyc(3);

    // Basic ADSR, all rates 0
    gate = 1'b1;
    cyc(2);
    chk("attack_state", 32'(state), 1);
    chk("attack_busy", 32'(busy), 1);
    wait_state(3'd2, 1200, n);
    chk("decay_state", 32'(state), 2);
    chk("decay_entry_level", 32'(level), 255);
    chk("attack_cycles_in_range", 32'((n + 2 >= 1018) && (n + 2 <= 1021)), 1);
    wait_state(3'd3, 600, n);
    chk("sustain_state", 32'(state), 3);
    chk("decay_cycles", 32'(n), 509);
    chk("sustain_level", 32'(level), 128);
    cyc(1);
    chk("samp_255x128", 32'(samp_out), 127);

    // Sustain tracking and output scaling
    sustain_level = 8'd200;
    cyc(1);
    chk("sustain_track", 32'(level), 200);
    samp_in = 8'd200;
    sustain_level = 8'd100;
    cyc(1);
    chk("sustain_100", 32'(level), 100);
    cyc(1);
    chk("samp_200x100", 32'(samp_out), 78);
    samp_in = 8'd0;
    cyc(1);
    chk("samp_zero_in", 32'(samp_out), 0);
    samp_in = 8'd255;
    sustain_level = 8'd128;
    cyc(1);

    // Release from 128
    gate = 1'b0;
    cyc(1);
    chk("release_state", 32'(state), 4);
    wait_state(3'd0, 600, n);
    chk("idle_state", 32'(state), 0);
    chk("idle_level", 32'(level), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("release_cycles_in_range", 32'((n >= 509) && (n <= 512)), 1);

    // Attack rate scaling: one step per 16 cycles
    attack_rate = 8'd3;
    gate = 1'b1;
    cyc(1);
    chk("rate_attack_state", 32'(state), 1);
    cyc(160);
    chk("rate_level_160", 32'(level), 10);
    chk("rate_still_attack", 32'(state), 1);

    // Retrigger mid-release at level 60
    attack_rate = 8'd0;
    wait_level(8'd61, 400, n);
    chk("pre_retrig_level", 32'(level), 61);
    gate = 1'b0;
    cyc(1);
    chk("retrig_release_state", 32'(state), 4);
    wait_level(8'd60, 10, n);
    chk("retrig_release_level", 32'(level), 60);
    gate = 1'b1;
    cyc(1);
    chk("retrig_state", 32'(state), 1);
    chk("retrig_level0", 32'(level), 32'(exp_retrig0));
    n = 0;
    while (32'(level) == exp_retrig0 && n < 10) begin
      cyc(1);
      n++;
    end
    chk("retrig_level1", 32'(level), 32'(exp_retrig1));

    // Fast path: sustain 255 leaves DECAY in one cycle
    sustain_level = 8'd255;
    wait_state(3'd2, 1100, n);
    chk("fast_decay_state", 32'(state), 2);
    chk("fast_decay_level", 32'(level), 255);
    cyc(1);
    chk("fast_sustain_state", 32'(state), 3);
    chk("fast_sustain_level", 32'(level), 255);
    chk("samp_255x255", 32'(samp_out), 254);

    // Async reset mid-attack at level 77
    gate = 1'b0;
    sustain_level = 8'd128;
    wait_state(3'd0, 1200, n);
    chk("pre_reset_idle", 32'(state), 0);
    gate = 1'b1;
    wait_level(8'd77, 400, n);
    chk("pre_reset_level", 32'(level), 77);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_level", 32'(level), 0);
    chk("async_rst_samp_out", 32'(samp_out), 0);
    chk("async_rst_busy", 32'(busy), 0);
    cyc(2);
    reset = 1'b1;
    cyc(10);
    chk("held_gate_no_attack", 32'(state), 0);
    chk("held_gate_level", 32'(level), 0);
    gate = 1'b0;
    cyc(1);
    gate = 1'b1;
    cyc(2);
    chk("recycled_gate_attack", 32'(state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
